// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO in front of Data_Memory with load forwarding.
// Owns the memory port; a missing load or a head drain gets it each cycle, never both.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [AW-1:0]              st_addr,
  input  logic [DW-1:0]              st_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [AW-1:0]              ld_addr,
  output logic                       ld_rvalid,
  output logic [DW-1:0]              ld_rdata,
  output logic                       misalign,
  output logic [$clog2(DEPTH):0]     sb_count,
  output logic                       sb_empty,
  output logic                       mem_readEn,
  output logic                       mem_writeEn,
  output logic [AW-1:0]              mem_address,
  output logic [DW-1:0]              mem_WriteData,
  input  logic [DW-1:0]              mem_ReadData
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {RUN, FLUSH} state_t;
  state_t          state;
  logic [AW-3:0]   addr_q [DEPTH];
  logic [DW-1:0]   data_q [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, count_nx;
  logic            hit, full, run, ld_acc, st_acc, drain;
  logic [DW-1:0]   fwd_data;
  // Scan oldest to youngest so the last match is the youngest pending store.
  always_comb begin
    hit = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count && addr_q[rd_ptr + PW'(k)] == ld_addr[AW-1:2]) begin
        hit = 1'b1;
        fwd_data = data_q[rd_ptr + PW'(k)];
      end
    end
  end
  assign run           = rst && state == RUN;
  assign full          = count == CW'(DEPTH);
  assign st_ready      = run && !full;
  assign ld_ready      = run && !(!hit && full);
  assign ld_acc        = ld_valid && ld_ready;
  assign st_acc        = st_valid && st_ready;
  assign mem_readEn    = ld_acc && !hit;
  assign mem_writeEn   = rst && !mem_readEn && count != '0;
  assign drain         = mem_writeEn;
  assign mem_address   = mem_readEn ? {ld_addr[AW-1:2], 2'b00} : {addr_q[rd_ptr], 2'b00};
  assign mem_WriteData = data_q[rd_ptr];
  assign count_nx      = count + CW'(st_acc) - CW'(drain);
  assign sb_count      = count;
  always_ff @(posedge clk) begin
    if (st_acc) begin
      addr_q[wr_ptr] <= st_addr[AW-1:2];
      data_q[wr_ptr] <= st_data;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ld_rvalid <= 1'b0;
      ld_rdata  <= '0;
      misalign  <= 1'b0;
      sb_empty  <= 1'b1;
    end else begin
      state     <= state == RUN ? (flush ? FLUSH : RUN) : (count == '0 && !flush ? RUN : FLUSH);
      if (st_acc) wr_ptr <= wr_ptr + 1'b1;
      if (drain) rd_ptr <= rd_ptr + 1'b1;
      count     <= count_nx;
      ld_rvalid <= ld_acc;
      if (ld_acc) ld_rdata <= hit ? fwd_data : mem_ReadData;
      misalign  <= (ld_acc && ld_addr[1:0] != 2'b00) || (st_acc && st_addr[1:0] != 2'b00);
      sb_empty  <= count_nx == '0 && !ld_acc;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios plus random traffic against a queue-based model
// of the store buffer and a word-addressed memory that acts on the falling edge.
module tb_store_buffer;
  localparam int DEPTH = 4;
  logic        clk = 0, rst = 0, flush = 0, st_valid = 0, ld_valid = 0;
  logic [31:0] st_addr = 0, st_data = 0, ld_addr = 0, mem_ReadData = 0;
  logic        st_ready, ld_ready, ld_rvalid, misalign, sb_empty, mem_readEn, mem_writeEn;
  logic [31:0] ld_rdata, mem_address, mem_WriteData;
  logic [2:0]  sb_count;
  int errs = 0, checks = 0;

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .misalign(misalign),
    .sb_count(sb_count), .sb_empty(sb_empty),
    .mem_readEn(mem_readEn), .mem_writeEn(mem_writeEn), .mem_address(mem_address),
    .mem_WriteData(mem_WriteData), .mem_ReadData(mem_ReadData)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  logic [31:0] dmem [logic [29:0]];
  always @(negedge clk) begin
    if (mem_writeEn) dmem[mem_address[31:2]] = mem_WriteData;
    if (mem_readEn) mem_ReadData <= dmem.exists(mem_address[31:2]) ? dmem[mem_address[31:2]] : 32'h0;
  end

  typedef struct {logic [29:0] a; logic [31:0] d;} ent_t;
  ent_t        q[$];
  logic [31:0] rmem [logic [29:0]];
  bit          fmode = 0, e_rv = 0, e_mis = 0, e_empty = 1;
  logic [31:0] e_rdata = 0;

  always @(posedge clk) begin : model
    bit hit, full, e_ldr, e_str, e_rd, e_wr, la, sa;
    int n;
    logic [31:0] fwd;
    #4;
    if (!rst) begin
      q.delete();
      fmode = 0; e_rv = 0; e_mis = 0; e_rdata = 0; e_empty = 1;
      chk("rst_readEn", mem_readEn, 0);
      chk("rst_writeEn", mem_writeEn, 0);
      chk("rst_rvalid", ld_rvalid, 0);
      chk("rst_rdata", ld_rdata, 0);
      chk("rst_misalign", misalign, 0);
      chk("rst_count", sb_count, 0);
      chk("rst_empty", sb_empty, 1);
    end else begin
      hit = 0; fwd = 0;
      foreach (q[i]) if (q[i].a == ld_addr[31:2]) begin hit = 1; fwd = q[i].d; end
      n = q.size();
      full = n == DEPTH;
      e_ldr = !fmode && !(!hit && full);
      e_str = !fmode && !full;
      e_rd = ld_valid && e_ldr && !hit;
      e_wr = !e_rd && n > 0;
      chk("st_ready", st_ready, e_str);
      chk("ld_ready", ld_ready, e_ldr);
      chk("mem_readEn", mem_readEn, e_rd);
      chk("mem_writeEn", mem_writeEn, e_wr);
      if (e_rd) chk("rd_addr", mem_address, {ld_addr[31:2], 2'b00});
      if (e_wr) begin
        chk("wr_addr", mem_address, {q[0].a, 2'b00});
        chk("wr_data", mem_WriteData, q[0].d);
      end
      chk("ld_rvalid", ld_rvalid, e_rv);
      chk("ld_rdata", ld_rdata, e_rdata);
      chk("misalign", misalign, e_mis);
      chk("sb_count", sb_count, n);
      chk("sb_empty", sb_empty, e_empty);
      la = ld_valid && e_ldr;
      sa = st_valid && e_str;
      e_rv = la;
      if (la) e_rdata = hit ? fwd : (rmem.exists(ld_addr[31:2]) ? rmem[ld_addr[31:2]] : 32'h0);
      if (e_wr) begin rmem[q[0].a] = q[0].d; void'(q.pop_front()); end
      if (sa) q.push_back('{st_addr[31:2], st_data});
      e_mis = (la && ld_addr[1:0] != 0) || (sa && st_addr[1:0] != 0);
      fmode = !fmode ? flush : !(n == 0 && !flush);
      e_empty = q.size() == 0 && !la;
    end
  end

  task automatic step(bit sv, logic [31:0] sa, logic [31:0] sd, bit lv, logic [31:0] la, bit fl);
    @(posedge clk);
    #1;
    st_valid = sv; st_addr = sa; st_data = sd; ld_valid = lv; ld_addr = la; flush = fl;
  endtask

  function automatic logic [31:0] raddr();
    return (32'($urandom_range(0, 7)) << 2) | ($urandom_range(0, 9) == 0 ? 32'($urandom_range(1, 3)) : 32'h0);
  endfunction

  initial begin
    int hold = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    #3;
    chk("t0_count", sb_count, 0);
    chk("t0_empty", sb_empty, 1);
    step(1, 32'h10, 32'hDEADBEEF, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    #3;
    chk("t1_count1", sb_count, 1);
    chk("t1_writeEn", mem_writeEn, 1);
    chk("t1_addr", mem_address, 32'h10);
    chk("t1_data", mem_WriteData, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 0);
    #3 chk("t1_count0", sb_count, 0);
    for (int i = 0; i < 4; i++) step(1, 32'(i * 4), 32'(i + 100), 1, 32'h100, 0);
    step(0, 0, 0, 1, 32'h100, 0);
    #3;
    chk("t2_count", sb_count, 4);
    chk("t2_st_ready", st_ready, 0);
    chk("t2_ld_ready", ld_ready, 0);
    chk("t2_drain0", mem_address, 32'h0);
    for (int i = 1; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      #3 chk("t2_drain_order", mem_address, 32'(i * 4));
    end
    step(1, 32'h20, 1, 0, 0, 0);
    step(1, 32'h20, 2, 0, 0, 0);
    step(0, 0, 0, 1, 32'h22, 0);
    #3 chk("t3_no_readEn", mem_readEn, 0);
    step(0, 0, 0, 0, 0, 0);
    #3;
    chk("t3_rvalid", ld_rvalid, 1);
    chk("t3_rdata", ld_rdata, 2);
    chk("t3_misalign", misalign, 1);
    step(1, 32'h30, 5, 1, 32'h30, 0);
    step(0, 0, 0, 1, 32'h30, 0);
    #3 chk("t4_rdata_old", ld_rdata, 0);
    step(0, 0, 0, 0, 0, 0);
    #3 chk("t4_rdata_new", ld_rdata, 5);
    for (int i = 0; i < 3; i++) step(1, 32'h40 + 32'(i * 4), 32'(i + 7), 1, 32'h200, 0);
    step(0, 0, 0, 0, 0, 1);
    #3 chk("t5_count", sb_count, 3);
    step(1, 32'h60, 9, 1, 32'h64, 1);
    #3;
    chk("t5_st_ready", st_ready, 0);
    chk("t5_ld_ready", ld_ready, 0);
    chk("t5_writeEn", mem_writeEn, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    #3 chk("t5_empty", sb_empty, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    #3 chk("t5_run", st_ready, 1);
    step(1, 32'h50, 11, 1, 32'h300, 0);
    step(1, 32'h54, 12, 1, 32'h300, 0);
    step(0, 0, 0, 0, 0, 0);
    #1 rst = 0;
    #2;
    chk("t6_writeEn", mem_writeEn, 0);
    chk("t6_count", sb_count, 0);
    @(posedge clk);
    #1 rst = 1;
    step(0, 0, 0, 0, 0, 0);
    #3;
    chk("t6_no_write", mem_writeEn, 0);
    chk("t6_count_after", sb_count, 0);
    for (int c = 0; c < 3000; c++) begin
      if (hold > 0) hold--;
      else if ($urandom_range(0, 99) == 0) hold = $urandom_range(1, 8);
      step($urandom_range(0, 1) == 0, raddr(), $urandom, $urandom_range(0, 2) == 0, raddr(), hold > 0);
    end
    step(0, 0, 0, 0, 0, 0);
    repeat (10) @(posedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
